// File: rtl/csp_channel_pkg.sv
// Shared types and helpers for the single-token CSP channel.
package csp_channel_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_HOLD
  } sender_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_REQ,
    R_RTZ
  } receiver_state_t;

  // Width of the latency counters: enough to hold max(fl, bl), never less than one bit.
  function automatic int cnt_width(input int fl, input int bl);
    int m;
    m = (fl > bl) ? fl : bl;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/csp_latency_counter.sv
// Loadable down-counter; done flags the final count so an FSM can leave on that edge.
module csp_latency_counter
#(
  parameter int MAX_COUNT = 2,
  parameter int CNT_W     = 2
)(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(MAX_COUNT);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/csp_channel.sv
// Single-token four-phase channel with programmable forward (FL) and backward (BL) latency.
// Optional probe outputs (probe, peek_data) are enabled by defining CSP_CHANNEL_PROBE_EN.
module csp_channel
  import csp_channel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FL    = 2,
  parameter int BL    = 2
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_req,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ack,
  output logic             r_req,
  output logic [WIDTH-1:0] r_data,
  input  logic             r_ack
`ifdef CSP_CHANNEL_PROBE_EN
  ,
  output logic             probe,
  output logic [WIDTH-1:0] peek_data
`endif
);

  localparam int CNT_W = cnt_width(FL, BL);

  sender_state_t   s_state;
  receiver_state_t r_state;
  logic             full;
  logic [WIDTH-1:0] data_buf;
  logic             capture;
  logic             release_tok;
  logic             fl_load;
  logic             bl_load;
  logic             fl_done;
  logic             bl_done;

  // Sender sees only the registered full, so a freed slot is reusable one edge later.
  assign capture     = (s_state == S_IDLE) && s_req && !full;
  assign release_tok = (r_state == R_REQ) && r_ack;
  assign bl_load     = (s_state == S_ACK) && !s_req;
  assign fl_load     = (r_state == R_IDLE) && full;

  csp_latency_counter #(.MAX_COUNT(FL), .CNT_W(CNT_W)) u_fl_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (fl_load),
    .done  (fl_done)
  );

  csp_latency_counter #(.MAX_COUNT(BL), .CNT_W(CNT_W)) u_bl_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (bl_load),
    .done  (bl_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      data_buf <= '0;
    end else if (capture) begin
      full     <= 1'b1;
      data_buf <= s_data;
    end else if (release_tok) begin
      full     <= 1'b0;
    end
  end

  assign r_data = data_buf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_state <= S_IDLE;
      s_ack   <= 1'b0;
    end else begin
      case (s_state)
        S_IDLE: begin
          if (capture) begin
            s_ack   <= 1'b1;
            s_state <= S_ACK;
          end
        end
        S_ACK: begin
          if (!s_req) begin
            s_ack   <= 1'b0;
            s_state <= (BL == 0) ? S_IDLE : S_HOLD;
          end
        end
        S_HOLD: begin
          if (bl_done) s_state <= S_IDLE;
        end
        default: s_state <= S_IDLE;
      endcase
    end
  end

  // r_ack is deliberately ignored outside R_REQ/R_RTZ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      r_req   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (full) begin
            if (FL == 0) begin
              r_req   <= 1'b1;
              r_state <= R_REQ;
            end else begin
              r_state <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (fl_done) begin
            r_req   <= 1'b1;
            r_state <= R_REQ;
          end
        end
        R_REQ: begin
          if (r_ack) begin
            r_req   <= 1'b0;
            r_state <= R_RTZ;
          end
        end
        R_RTZ: begin
          if (!r_ack) r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

`ifdef CSP_CHANNEL_PROBE_EN
  assign probe     = full;
  assign peek_data = data_buf;
`endif

endmodule

// File: tb/tb_csp_channel.sv
// Scoreboard bench: channel A (FL=2, BL=2) and channel B (FL=0, BL=0) share clock and reset.
module tb_csp_channel;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_req_a = 1'b0, s_ack_a, r_req_a, r_ack_a = 1'b0;
  logic [7:0] s_data_a = '0, r_data_a;
  logic       s_req_b = 1'b0, s_ack_b, r_req_b, r_ack_b = 1'b0;
  logic [7:0] s_data_b = '0, r_data_b;
  logic       rx_hold = 1'b0;
`ifdef CSP_CHANNEL_PROBE_EN
  logic       probe_a, probe_b;
  logic [7:0] peek_a, peek_b;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  always #5 clk = ~clk;

  csp_channel #(.WIDTH(8), .FL(2), .BL(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_req(s_req_a), .s_data(s_data_a), .s_ack(s_ack_a),
    .r_req(r_req_a), .r_data(r_data_a), .r_ack(r_ack_a)
`ifdef CSP_CHANNEL_PROBE_EN
    , .probe(probe_a), .peek_data(peek_a)
`endif
  );

  csp_channel #(.WIDTH(8), .FL(0), .BL(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_req(s_req_b), .s_data(s_data_b), .s_ack(s_ack_b),
    .r_req(r_req_b), .r_data(r_data_b), .r_ack(r_ack_b)
`ifdef CSP_CHANNEL_PROBE_EN
    , .probe(probe_b), .peek_data(peek_b)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Receivers: A acknowledges unless held back, B acknowledges immediately.
  initial forever begin
    @(posedge clk);
    #2;
    r_ack_a = rst_n && r_req_a && !rx_hold;
    r_ack_b = rst_n && r_req_b;
  end

  // Monitor: pop the expected token on each r_req rise, then hold r_data to it while r_req stays high.
  initial begin
    logic prev_a, prev_b;
    logic [7:0] cur_a, cur_b;
    prev_a = 1'b0; prev_b = 1'b0; cur_a = '0; cur_b = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (r_req_a && !prev_a) begin
          if (exp_a.size() == 0) chk("sb_a_unexpected", {24'd0, r_data_a}, 32'hFFFF_FFFF);
          else begin
            cur_a = exp_a.pop_front();
            chk("sb_a_data", {24'd0, r_data_a}, {24'd0, cur_a});
          end
        end else if (r_req_a) chk("sb_a_stable", {24'd0, r_data_a}, {24'd0, cur_a});
        if (r_req_b && !prev_b) begin
          if (exp_b.size() == 0) chk("sb_b_unexpected", {24'd0, r_data_b}, 32'hFFFF_FFFF);
          else begin
            cur_b = exp_b.pop_front();
            chk("sb_b_data", {24'd0, r_data_b}, {24'd0, cur_b});
          end
        end
      end
      prev_a = r_req_a;
      prev_b = r_req_b;
    end
  end

  task automatic send_a(input logic [7:0] d);
    int n;
    s_req_a = 1'b1; s_data_a = d; exp_a.push_back(d);
    n = 0;
    while (!s_ack_a && n < 60) begin tick(); n++; end
    chk("send_a_ack", {31'd0, s_ack_a}, 32'd1);
    s_req_a = 1'b0;
    n = 0;
    while (s_ack_a && n < 60) begin tick(); n++; end
  endtask

  task automatic send_b(input logic [7:0] d);
    int n;
    s_req_b = 1'b1; s_data_b = d; exp_b.push_back(d);
    n = 0;
    while (!s_ack_b && n < 60) begin tick(); n++; end
    chk("send_b_ack", {31'd0, s_ack_b}, 32'd1);
    s_req_b = 1'b0;
    n = 0;
    while (s_ack_b && n < 60) begin tick(); n++; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0 || r_req_a || r_req_b) && n < 100) begin
      tick(); n++;
    end
    chk("drain_timeout", n, (n < 100) ? n : 32'hFFFF_FFFF);
    repeat (3) tick();
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) tick();
    chk("rst_s_ack_a", {31'd0, s_ack_a}, 32'd0);
    chk("rst_r_req_a", {31'd0, r_req_a}, 32'd0);
    chk("rst_r_data_a", {24'd0, r_data_a}, 32'd0);
    chk("rst_r_req_b", {31'd0, r_req_b}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic transfer 0x5A: r_req rises three edges after capture
    s_req_a = 1'b1; s_data_a = 8'h5A; exp_a.push_back(8'h5A);
    tick();
    chk("basic_ack", {31'd0, s_ack_a}, 32'd1);
    chk("basic_rreq0", {31'd0, r_req_a}, 32'd0);
    s_req_a = 1'b0;
    tick();
    chk("basic_ack_rtz", {31'd0, s_ack_a}, 32'd0);
    chk("basic_rreq1", {31'd0, r_req_a}, 32'd0);
    tick();
    chk("basic_rreq2", {31'd0, r_req_a}, 32'd0);
    tick();
    chk("basic_rreq3", {31'd0, r_req_a}, 32'd1);
    chk("basic_rdata", {24'd0, r_data_a}, 32'h5A);
    tick();
    chk("basic_rreq_fall", {31'd0, r_req_a}, 32'd0);
    drain();

    // Backpressure: 0x22 must wait for 0x11 to be acknowledged
    rx_hold = 1'b1;
    s_req_a = 1'b1; s_data_a = 8'h11; exp_a.push_back(8'h11);
    tick();
    chk("bp_ack1", {31'd0, s_ack_a}, 32'd1);
    s_req_a = 1'b0;
    tick();
    chk("bp_ack1_rtz", {31'd0, s_ack_a}, 32'd0);
    s_req_a = 1'b1; s_data_a = 8'h22; exp_a.push_back(8'h22);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("bp_ack_blocked", {31'd0, s_ack_a}, 32'd0);
    end
    chk("bp_rreq_held", {31'd0, r_req_a}, 32'd1);
    rx_hold = 1'b0;
    tick();
    chk("bp_rreq_until_ack", {31'd0, r_req_a}, 32'd1);
    tick();
    chk("bp_rreq_released", {31'd0, r_req_a}, 32'd0);
    chk("bp_no_bypass", {31'd0, s_ack_a}, 32'd0);
    tick();
    chk("bp_ack2", {31'd0, s_ack_a}, 32'd1);
    s_req_a = 1'b0;
    drain();

    // BL holdoff: second capture exactly BL+1 edges after s_ack falls
    s_req_a = 1'b1; s_data_a = 8'h33; exp_a.push_back(8'h33);
    tick();
    chk("bl_ack1", {31'd0, s_ack_a}, 32'd1);
    repeat (5) tick();
    s_req_a = 1'b0;
    tick();
    chk("bl_ack_fall", {31'd0, s_ack_a}, 32'd0);
    s_req_a = 1'b1; s_data_a = 8'h44; exp_a.push_back(8'h44);
    tick();
    chk("bl_hold_k1", {31'd0, s_ack_a}, 32'd0);
    tick();
    chk("bl_hold_k2", {31'd0, s_ack_a}, 32'd0);
    tick();
    chk("bl_capture_k3", {31'd0, s_ack_a}, 32'd1);
    s_req_a = 1'b0;
    drain();

    // FL=0/BL=0 stream: r_req one edge after capture, then 0x02..0x04 back to back
    s_req_b = 1'b1; s_data_b = 8'h01; exp_b.push_back(8'h01);
    tick();
    chk("fl0_ack", {31'd0, s_ack_b}, 32'd1);
    chk("fl0_rreq0", {31'd0, r_req_b}, 32'd0);
    s_req_b = 1'b0;
    tick();
    chk("fl0_rreq1", {31'd0, r_req_b}, 32'd1);
    chk("fl0_rdata", {24'd0, r_data_b}, 32'h01);
    for (int i = 2; i <= 4; i++) send_b(8'(i));
    drain();

    // Async reset while r_req is high drops the token immediately
    rx_hold = 1'b1;
    send_a(8'h99);
    n = 0;
    while (!r_req_a && n < 20) begin tick(); n++; end
    chk("rst_pre_rreq", {31'd0, r_req_a}, 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_r_req", {31'd0, r_req_a}, 32'd0);
    chk("arst_s_ack", {31'd0, s_ack_a}, 32'd0);
    chk("arst_r_data", {24'd0, r_data_a}, 32'd0);
    rx_hold = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    send_a(8'hC3);
    drain();

`ifdef CSP_CHANNEL_PROBE_EN
    rx_hold = 1'b1;
    s_req_a = 1'b1; s_data_a = 8'h7E; exp_a.push_back(8'h7E);
    tick();
    chk("probe_set", {31'd0, probe_a}, 32'd1);
    chk("probe_peek", {24'd0, peek_a}, 32'h7E);
    chk("probe_rreq0", {31'd0, r_req_a}, 32'd0);
    s_req_a = 1'b0;
    n = 0;
    while (!r_req_a && n < 20) begin tick(); n++; end
    rx_hold = 1'b0;
    drain();
    chk("probe_clear", {31'd0, probe_a}, 32'd0);
`endif

    chk("sb_a_all_delivered", exp_a.size(), 32'd0);
    chk("sb_b_all_delivered", exp_b.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
